// File: rtl/layer1_result_ctrl_pkg.sv
// Shared types and constants for the layer-1 result buffer controller.
package layer1_result_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } l1res_state_t;

    localparam int LAYER2_WIDTH         = 30;
    localparam int LAYER1_OUTPUT_LENGTH = 128;

    // row*30 + col without a multiplier; valid for in-range coordinates only
    function automatic logic [10:0] l1res_lin_idx(input logic [15:0] row, input logic [15:0] col);
        logic [15:0] row_x30;
        row_x30 = (row << 5) - (row << 1);
        return {1'b0, row_x30[9:0]} + col[10:0];
    endfunction

endpackage

// File: rtl/layer1_result_ctrl_raster_cnt.sv
// Raster-order write position: column/row coordinates plus linear entry count.
module l1res_raster_cnt #(
    parameter int WIDTH = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] row,
    output logic [15:0] col,
    output logic [10:0] cnt
);

    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic [10:0] cnt_q, cnt_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        cnt_d = cnt_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 11'd1;
            if (col_q == 16'(WIDTH - 1)) begin
                col_d = '0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
            cnt_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

    assign row = row_q;
    assign col = col_q;
    assign cnt = cnt_q;

endmodule

// File: rtl/layer1_result_ctrl.sv
// Write sequencer and read-after-write guard for the layer-1 result SRAM.
module layer1_result_ctrl
    import layer1_result_ctrl_pkg::*;
#(
    parameter int WIDTH  = LAYER2_WIDTH,
    parameter int DATA_W = LAYER1_OUTPUT_LENGTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              save_enable,
    output logic [15:0]       save_row_addr,
    output logic [15:0]       save_col_addr,
    output logic [DATA_W-1:0] layer1_result_store_data_in,
    input  logic              rd_req,
    input  logic [15:0]       rd_row,
    input  logic [15:0]       rd_col,
    output logic              rd_grant,
    output logic              rd_err,
    output logic              rd_data_valid,
    output logic [15:0]       read_row_addr,
    output logic [15:0]       read_col_addr,
    output logic              layer1_result_read_signal,
    output logic              busy,
    output logic              done
);

    localparam logic [10:0] LAST_IDX = 11'(WIDTH * WIDTH - 1);
    localparam logic [15:0] WIDTH16  = 16'(WIDTH);

    l1res_state_t state_q, state_d;
    logic [15:0]  read_row_q, read_row_d;
    logic [15:0]  read_col_q, read_col_d;
    logic         issue_q, issue_d;
    logic         rsig_q, rsig_d;
    logic         valid_q, valid_d;

    logic         accept;
    logic         in_range;
    logic [10:0]  rd_lin;
    logic [10:0]  wr_cnt;

    l1res_raster_cnt #(.WIDTH(WIDTH)) u_raster_cnt (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (accept),
        .row (save_row_addr),
        .col (save_col_addr),
        .cnt (wr_cnt)
    );

    generate
        if (WIDTH == 30) begin : g_lin_shift
            assign rd_lin = l1res_lin_idx(rd_row, rd_col);
        end else begin : g_lin_mul
            assign rd_lin = 11'(rd_row * WIDTH16 + rd_col);
        end
    endgenerate

    assign in_ready    = (state_q == FILL) && !start;
    assign accept      = in_valid && in_ready;
    assign save_enable = accept;
    assign layer1_result_store_data_in = in_data;

    // An entry is readable once counted in wr_cnt, i.e. the cycle after its write.
    assign in_range = (rd_row < WIDTH16) && (rd_col < WIDTH16);
    assign rd_err   = rd_req && !in_range;
    assign rd_grant = rd_req && in_range &&
                      ((state_q == DONE) || ((state_q == FILL) && (rd_lin < wr_cnt)));

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = FILL;
        end else if ((state_q == FILL) && accept && (wr_cnt == LAST_IDX)) begin
            state_d = DONE;
        end
        read_row_d = rd_grant ? rd_row : read_row_q;
        read_col_d = rd_grant ? rd_col : read_col_q;
        issue_d    = rd_grant;
        // Output enable spans the address cycle and the data-valid cycle.
        rsig_d     = rd_grant || issue_q;
        valid_d    = issue_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            read_row_q <= '0;
            read_col_q <= '0;
            issue_q    <= 1'b0;
            rsig_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            read_row_q <= read_row_d;
            read_col_q <= read_col_d;
            issue_q    <= issue_d;
            rsig_q     <= rsig_d;
            valid_q    <= valid_d;
        end
    end

    assign read_row_addr             = read_row_q;
    assign read_col_addr             = read_col_q;
    assign layer1_result_read_signal = rsig_q;
    assign rd_data_valid             = valid_q;
    assign busy                      = (state_q == FILL);
    assign done                      = (state_q == DONE);

endmodule

// File: tb/tb_layer1_result_ctrl.sv
// Self-checking bench: behavioural SRAM on the write/read ports plus a read-data scoreboard.
module tb_layer1_result_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         save_enable;
    logic [15:0]  save_row_addr;
    logic [15:0]  save_col_addr;
    logic [127:0] layer1_result_store_data_in;
    logic         rd_req;
    logic [15:0]  rd_row;
    logic [15:0]  rd_col;
    logic         rd_grant;
    logic         rd_err;
    logic         rd_data_valid;
    logic [15:0]  read_row_addr;
    logic [15:0]  read_col_addr;
    logic         layer1_result_read_signal;
    logic         busy;
    logic         done;

    layer1_result_ctrl #(.WIDTH(30), .DATA_W(128)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .start                       (start),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .in_data                     (in_data),
        .save_enable                 (save_enable),
        .save_row_addr               (save_row_addr),
        .save_col_addr               (save_col_addr),
        .layer1_result_store_data_in (layer1_result_store_data_in),
        .rd_req                      (rd_req),
        .rd_row                      (rd_row),
        .rd_col                      (rd_col),
        .rd_grant                    (rd_grant),
        .rd_err                      (rd_err),
        .rd_data_valid               (rd_data_valid),
        .read_row_addr               (read_row_addr),
        .read_col_addr               (read_col_addr),
        .layer1_result_read_signal   (layer1_result_read_signal),
        .busy                        (busy),
        .done                        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           valid_seen = 0;
    logic [127:0] golden [0:899];
    logic [127:0] mem    [0:899];
    logic [127:0] sram_q;
    logic [127:0] sb_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lin(input int r, input int c);
        return r * 30 + c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM model (falling-edge write and read capture) and read-data scoreboard
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rd_data_valid) begin
                valid_seen++;
                check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
                if (sb_q.size() != 0) begin
                    logic [127:0] exp_v;
                    exp_v = sb_q.pop_front();
                    check("rd_data", sram_q, exp_v);
                    $display("read data %0h expected %0h", sram_q, exp_v);
                end
            end
            if (rd_grant) sb_q.push_back(golden[lin(int'(rd_row), int'(rd_col))]);
            if (save_enable && save_row_addr < 30 && save_col_addr < 30)
                mem[lin(int'(save_row_addr), int'(save_col_addr))] = layer1_result_store_data_in;
            if (layer1_result_read_signal && read_row_addr < 30 && read_col_addr < 30)
                sram_q = mem[lin(int'(read_row_addr), int'(read_col_addr))];
        end
    end

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        #1;
        check("in_ready_during_start", 128'(in_ready), 128'(0));
        tick();
        start = 1'b0;
    endtask

    initial begin
        int vs0;
        logic [15:0] rr, cc;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        rd_req = 1'b0; rd_row = '0; rd_col = '0;
        tick(); tick();
        check("reset_outputs",
              128'({in_ready, save_enable, rd_grant, rd_err, rd_data_valid,
                    layer1_result_read_signal, busy, done,
                    read_row_addr, read_col_addr, save_row_addr, save_col_addr}), 128'(0));
        rst = 1'b0;
        tick();

        // Frame 1: 900 beats, data = index, with the write-to-read hazard probe
        pulse_start();
        check("busy_after_start", 128'({busy, done}), 128'(2'b10));
        for (int i = 0; i < 900; i++) begin
            in_valid = 1'b1;
            in_data  = 128'(i);
            golden[i] = 128'(i);
            if (i == 30) begin rd_req = 1'b1; rd_row = 16'd1; rd_col = 16'd0; end
            if (i == 32) rd_req = 1'b0;
            #1;
            check("save_en", 128'({save_enable, in_ready}), 128'(2'b11));
            check("save_addr", 128'({save_row_addr, save_col_addr}), 128'({16'(i / 30), 16'(i % 30)}));
            if (i == 30) check("hazard_no_grant", 128'(rd_grant), 128'(0));
            if (i == 31) check("hazard_grant", 128'(rd_grant), 128'(1));
            if (i == 32) check("hazard_addr", 128'({read_row_addr, read_col_addr, layer1_result_read_signal, rd_data_valid}),
                               128'({16'd1, 16'd0, 1'b1, 1'b0}));
            if (i == 33) check("hazard_rdv", 128'({rd_data_valid, layer1_result_read_signal}), 128'(2'b11));
            if (i == 899) check("not_done_yet", 128'({busy, done}), 128'(2'b10));
            $display("beat %0d row %0d col %0d", i, save_row_addr, save_col_addr);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("done_state", 128'({busy, done, in_ready}), 128'(3'b010));

        // Out-of-range requests
        rd_req = 1'b1; rd_row = 16'd30; rd_col = 16'd5;
        #1;
        check("err_row", 128'({rd_err, rd_grant}), 128'(2'b10));
        tick();
        rd_row = 16'd5; rd_col = 16'd30;
        #1;
        check("err_col", 128'({rd_err, rd_grant}), 128'(2'b10));
        tick();
        rd_req = 1'b0;
        #1;
        check("err_pulse_end", 128'(rd_err), 128'(0));
        check("err_read_unchanged", 128'({read_row_addr, read_col_addr, layer1_result_read_signal}),
              128'({16'd1, 16'd0, 1'b0}));

        // DONE: five back-to-back reads
        vs0 = valid_seen;
        for (int j = 0; j < 5; j++) begin
            rr = (j == 0) ? 16'd29 : 16'($urandom_range(0, 29));
            cc = (j == 0) ? 16'd29 : 16'($urandom_range(0, 29));
            rd_req = 1'b1; rd_row = rr; rd_col = cc;
            #1;
            check("b2b_grant", 128'(rd_grant), 128'(1));
            if (j >= 2) check("b2b_rdv", 128'(rd_data_valid), 128'(1));
            $display("b2b read (%0d,%0d) grant %0b", rr, cc, rd_grant);
            tick();
        end
        rd_req = 1'b0;
        for (int j = 5; j < 8; j++) begin
            #1;
            check("b2b_rdv_tail", 128'(rd_data_valid), 128'(j < 7));
            tick();
        end
        check("b2b_valid_count", 128'(valid_seen - vs0), 128'(5));

        // Frame 2 then restart after 100 beats
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 128'(5000 + i); golden[i] = 128'(5000 + i);
            tick();
        end
        pulse_start();
        rd_req = 1'b1; rd_row = 16'd0; rd_col = 16'd5;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 128'(9000 + i); golden[i] = 128'(9000 + i);
            #1;
            check("restart_addr", 128'({save_row_addr, save_col_addr}), 128'({16'd0, 16'(i)}));
            check("restart_grant", 128'(rd_grant), 128'(i == 6));
            $display("restart beat %0d grant %0b", i, rd_grant);
            tick();
            if (i == 6) rd_req = 1'b0;
        end

        // Reset mid-FILL with a read in flight
        in_valid = 1'b0;
        rd_req = 1'b1; rd_row = 16'd0; rd_col = 16'd3;
        #1;
        check("pre_rst_grant", 128'(rd_grant), 128'(1));
        tick();
        rd_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs",
              128'({in_ready, save_enable, rd_grant, rd_err, rd_data_valid,
                    layer1_result_read_signal, busy, done,
                    read_row_addr, read_col_addr, save_row_addr, save_col_addr}), 128'(0));
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check("post_rst_idle", 128'({busy, done, in_ready, rd_data_valid}), 128'(0));
        rd_req = 1'b1; rd_row = 16'd0; rd_col = 16'd0;
        #1;
        check("idle_no_grant", 128'({rd_grant, rd_err}), 128'(0));
        rd_col = 16'd30;
        #1;
        check("idle_err", 128'({rd_grant, rd_err}), 128'(2'b01));
        tick();
        rd_req = 1'b0;
        tick(); tick();
        check("sb_empty", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
